// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states,
// datapath select codes and the bundled control word.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB,
        MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_OR    = 3'b011,
        ALU_AND   = 3'b100
    } aluop_t;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       sign;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] pcsource;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: maps the current state (plus op_q and the memory/zero
// qualifiers) onto the datapath control word.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  op_q,
    input  logic        mem_ready,
    input  logic        zero,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl       = '0;
        ctrl.aluop = ALU_ADD;
        case (state)
            FETCH: begin
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.pcsource = PCS_ALU;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH2;
                ctrl.sign    = 1'b1;
            end
            EXEC_R: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALU_FUNCT;
            end
            R_WB: begin
                ctrl.regdst     = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            EXEC_I: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                case (op_q)
                    OP_ANDI: ctrl.aluop = ALU_AND;
                    OP_ORI:  ctrl.aluop = ALU_OR;
                    default: begin
                        ctrl.aluop = ALU_ADD;
                        ctrl.sign  = 1'b1;
                    end
                endcase
            end
            I_WB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_ADDR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.sign    = 1'b1;
            end
            MEM_RD: ctrl.iord = 1'b1;
            MEM_WB: begin
                ctrl.memtoreg   = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_WR: begin
                ctrl.iord       = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            BRANCH: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_B;
                ctrl.aluop      = ALU_SUB;
                ctrl.pcsource   = PCS_ALUOUT;
                ctrl.pcwrite    = zero;
                ctrl.instr_done = 1'b1;
            end
            JUMP: begin
                ctrl.pcsource   = PCS_JUMP;
                ctrl.pcwrite    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control unit: state register, latched opcode, next-state logic
// and the retired-instruction counter around the output decoder.
module mc_control
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  OPcode,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IorD,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic        Sign,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOP,
    output logic [1:0]  PCSource,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] retired
);

    state_t      state, state_nx;
    logic [5:0]  op_q;
    logic [31:0] retired_q;
    logic        illegal_c;
    ctrl_t       dec, ctl;

    mc_ctrl_decode u_decode (
        .state     (state),
        .op_q      (op_q),
        .mem_ready (mem_ready),
        .zero      (Zero),
        .ctrl      (dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                op_q <= '0;
        else if (state == DECODE) op_q <= OPcode;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                retired_q <= '0;
        else if (dec.instr_done) retired_q <= retired_q + 32'd1;
    end

    // DECODE steers on the live OPcode since op_q only captures it at the edge leaving DECODE.
    always_comb begin
        state_nx  = state;
        illegal_c = 1'b0;
        case (state)
            FETCH: if (mem_ready) state_nx = DECODE;
            DECODE: begin
                case (OPcode)
                    OP_R:                      state_nx = EXEC_R;
                    OP_LW, OP_SW:              state_nx = MEM_ADDR;
                    OP_BEQ:                    state_nx = BRANCH;
                    OP_J:                      state_nx = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_nx = EXEC_I;
                    default: begin
                        state_nx  = FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            EXEC_R:   state_nx = R_WB;
            EXEC_I:   state_nx = I_WB;
            MEM_ADDR: state_nx = (op_q == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_nx = MEM_WB;
            MEM_WR:   if (mem_ready) state_nx = FETCH;
            default:  state_nx = FETCH;
        endcase
    end

    assign ctl        = rst ? dec : '0;
    assign PCWrite    = ctl.pcwrite;
    assign IRWrite    = ctl.irwrite;
    assign MemWrite   = ctl.memwrite;
    assign RegWrite   = ctl.regwrite;
    assign IorD       = ctl.iord;
    assign MemtoReg   = ctl.memtoreg;
    assign RegDst     = ctl.regdst;
    assign Sign       = ctl.sign;
    assign ALUSrcA    = ctl.alusrca;
    assign ALUSrcB    = ctl.alusrcb;
    assign ALUOP      = ctl.aluop;
    assign PCSource   = ctl.pcsource;
    assign instr_done = ctl.instr_done;
    assign illegal    = rst & illegal_c;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle control-word checks per instruction.
module tb_mc_control;

    localparam logic [5:0] T_R   = 6'b000000;
    localparam logic [5:0] T_LW  = 6'b100011;
    localparam logic [5:0] T_SW  = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100;
    localparam logic [5:0] T_J   = 6'b000010;
    localparam logic [5:0] T_ORI = 6'b001101;
    localparam logic [5:0] T_BAD = 6'b111111;

    logic        clk, rst, Zero, mem_ready;
    logic [5:0]  OPcode;
    logic        PCWrite, IRWrite, MemWrite, RegWrite, IorD, MemtoReg, RegDst, Sign, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ALUOP;
    logic        instr_done, illegal;
    logic [31:0] retired;
    logic [17:0] obs;

    int total = 0;
    int bad   = 0;

    logic [17:0] E_FETCH, E_FSTALL, E_DEC, E_DEC_ILL, E_EXR, E_RWB, E_EXI_ORI, E_IWB;
    logic [17:0] E_MADDR, E_MRD, E_MWB, E_MWR_W, E_MWR_D, E_BR_T, E_BR_N, E_JMP;

    mc_control dut (
        .clk(clk), .rst(rst), .OPcode(OPcode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IorD(IorD), .MemtoReg(MemtoReg), .RegDst(RegDst), .Sign(Sign), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOP(ALUOP), .PCSource(PCSource), .instr_done(instr_done),
        .illegal(illegal), .retired(retired)
    );

    assign obs = {PCWrite, IRWrite, MemWrite, RegWrite, IorD, MemtoReg, RegDst, Sign,
                  ALUSrcA, ALUSrcB, ALUOP, PCSource, instr_done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] cv(
        input logic pcw, irw, mw, rw, iord, m2r, rd, sg, sa,
        input logic [1:0] sb, input logic [2:0] aop, input logic [1:0] pcs,
        input logic done, ill);
        return {pcw, irw, mw, rw, iord, m2r, rd, sg, sa, sb, aop, pcs, done, ill};
    endfunction

    task automatic test_power_on;
        #3;
        total++;
        if (obs !== 18'd0) begin bad++; $display("FAIL por_outputs got=%b want=%b", obs, 18'd0); end
        total++;
        if (retired !== 32'd0) begin bad++; $display("FAIL por_retired got=%h want=%h", retired, 32'd0); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_lw;
        logic [17:0] exp [5];
        exp = '{E_FETCH, E_DEC, E_MADDR, E_MRD, E_MWB};
        OPcode = T_LW; mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1; total++;
            if (obs !== exp[k]) begin bad++; $display("FAIL lw_cyc%0d got=%b want=%b", k, obs, exp[k]); end
            if (k == 4) begin
                total++;
                if (retired !== 32'd0) begin bad++; $display("FAIL lw_pre_retired got=%0d want=0", retired); end
            end
            @(posedge clk); #1;
        end
        total++;
        if (retired !== 32'd1) begin bad++; $display("FAIL lw_retired got=%0d want=1", retired); end
    endtask

    task automatic test_sw_wait;
        logic [17:0] exp [7];
        logic        mr  [7];
        exp = '{E_FETCH, E_DEC, E_MADDR, E_MWR_W, E_MWR_W, E_MWR_W, E_MWR_D};
        mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        OPcode = T_SW;
        for (int k = 0; k < 7; k++) begin
            mem_ready = mr[k];
            #1; total++;
            if (obs !== exp[k]) begin bad++; $display("FAIL sw_cyc%0d got=%b want=%b", k, obs, exp[k]); end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        #1; total++;
        if (obs !== E_FETCH) begin bad++; $display("FAIL sw_back_to_fetch got=%b want=%b", obs, E_FETCH); end
        total++;
        if (retired !== 32'd2) begin bad++; $display("FAIL sw_retired got=%0d want=2", retired); end
    endtask

    task automatic test_beq;
        logic [17:0] exp [6];
        exp = '{E_FETCH, E_DEC, E_BR_T, E_FETCH, E_DEC, E_BR_N};
        OPcode = T_BEQ; mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            Zero = (k < 3);
            #1; total++;
            if (obs !== exp[k]) begin bad++; $display("FAIL beq_cyc%0d got=%b want=%b", k, obs, exp[k]); end
            @(posedge clk); #1;
        end
        Zero = 1'b0;
        total++;
        if (retired !== 32'd4) begin bad++; $display("FAIL beq_retired got=%0d want=4", retired); end
    endtask

    task automatic test_reset;
        logic [17:0] exp [3];
        exp = '{E_FETCH, E_DEC, E_MADDR};
        OPcode = T_LW; mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1; total++;
            if (obs !== exp[k]) begin bad++; $display("FAIL rst_pre_cyc%0d got=%b want=%b", k, obs, exp[k]); end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (obs !== E_MRD) begin bad++; $display("FAIL rst_in_memrd got=%b want=%b", obs, E_MRD); end
        #1 rst = 1'b0;
        #1; total++;
        if (obs !== 18'd0) begin bad++; $display("FAIL rst_outputs got=%b want=%b", obs, 18'd0); end
        total++;
        if (retired !== 32'd0) begin bad++; $display("FAIL rst_retired got=%0d want=0", retired); end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (obs !== 18'd0) begin bad++; $display("FAIL rst_held_outputs got=%b want=%b", obs, 18'd0); end
        rst = 1'b1;
        #1; total++;
        if (obs !== E_FETCH) begin bad++; $display("FAIL rst_release_fetch got=%b want=%b", obs, E_FETCH); end
        mem_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (obs !== E_FSTALL) begin bad++; $display("FAIL rst_fetch_stall got=%b want=%b", obs, E_FSTALL); end
        total++;
        if (retired !== 32'd0) begin bad++; $display("FAIL rst_after_retired got=%0d want=0", retired); end
    endtask

    task automatic test_sequence;
        logic [17:0] exp [14];
        logic [5:0]  ops [14];
        int          ill_cnt;
        exp = '{E_FETCH, E_DEC, E_EXR, E_RWB,
                E_FETCH, E_DEC, E_EXI_ORI, E_IWB,
                E_FETCH, E_DEC, E_JMP,
                E_FETCH, E_DEC_ILL, E_FETCH};
        ops = '{T_R, T_R, T_R, T_R, T_ORI, T_ORI, T_ORI, T_ORI,
                T_J, T_J, T_J, T_BAD, T_BAD, T_J};
        ill_cnt = 0;
        mem_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            OPcode = ops[k];
            #1; total++;
            if (obs !== exp[k]) begin bad++; $display("FAIL seq_cyc%0d got=%b want=%b", k, obs, exp[k]); end
            if (illegal === 1'b1) ill_cnt++;
            if (k == 13) mem_ready = 1'b0;
            @(posedge clk); #1;
        end
        total++;
        if (ill_cnt !== 1) begin bad++; $display("FAIL seq_illegal_pulses got=%0d want=1", ill_cnt); end
        total++;
        if (retired !== 32'd3) begin bad++; $display("FAIL seq_retired got=%0d want=3", retired); end
    endtask

    task automatic test_wrap;
        logic [17:0] exp [3];
        exp = '{E_FETCH, E_DEC, E_JMP};
        mem_ready = 1'b0;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1 release dut.retired_q;
        @(posedge clk); #1;
        total++;
        if (retired !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload got=%h want=ffffffff", retired); end
        OPcode = T_J; mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1; total++;
            if (obs !== exp[k]) begin bad++; $display("FAIL wrap_cyc%0d got=%b want=%b", k, obs, exp[k]); end
            @(posedge clk); #1;
        end
        total++;
        if (retired !== 32'd0) begin bad++; $display("FAIL wrap_retired got=%h want=00000000", retired); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        E_FETCH   = cv(1,1,0,0,0,0,0,0,0, 2'b01, 3'b000, 2'b00, 0, 0);
        E_FSTALL  = cv(0,0,0,0,0,0,0,0,0, 2'b01, 3'b000, 2'b00, 0, 0);
        E_DEC     = cv(0,0,0,0,0,0,0,1,0, 2'b11, 3'b000, 2'b00, 0, 0);
        E_DEC_ILL = cv(0,0,0,0,0,0,0,1,0, 2'b11, 3'b000, 2'b00, 0, 1);
        E_EXR     = cv(0,0,0,0,0,0,0,0,1, 2'b00, 3'b010, 2'b00, 0, 0);
        E_RWB     = cv(0,0,0,1,0,0,1,0,0, 2'b00, 3'b000, 2'b00, 1, 0);
        E_EXI_ORI = cv(0,0,0,0,0,0,0,0,1, 2'b10, 3'b011, 2'b00, 0, 0);
        E_IWB     = cv(0,0,0,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 1, 0);
        E_MADDR   = cv(0,0,0,0,0,0,0,1,1, 2'b10, 3'b000, 2'b00, 0, 0);
        E_MRD     = cv(0,0,0,0,1,0,0,0,0, 2'b00, 3'b000, 2'b00, 0, 0);
        E_MWB     = cv(0,0,0,1,0,1,0,0,0, 2'b00, 3'b000, 2'b00, 1, 0);
        E_MWR_W   = cv(0,0,1,0,1,0,0,0,0, 2'b00, 3'b000, 2'b00, 0, 0);
        E_MWR_D   = cv(0,0,1,0,1,0,0,0,0, 2'b00, 3'b000, 2'b00, 1, 0);
        E_BR_T    = cv(1,0,0,0,0,0,0,0,1, 2'b00, 3'b001, 2'b01, 1, 0);
        E_BR_N    = cv(0,0,0,0,0,0,0,0,1, 2'b00, 3'b001, 2'b01, 1, 0);
        E_JMP     = cv(1,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 1, 0);

        rst = 1'b0; OPcode = '0; Zero = 1'b0; mem_ready = 1'b1;
        test_power_on;
        test_lw;
        test_sw_wait;
        test_beq;
        test_reset;
        test_sequence;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
